// File: rtl/regfile_pkg.sv
// regfile_pkg: shared FSM state type and default sizing
// for the multi-port register file.
package regfile_pkg;

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    localparam int XLEN_DEF  = 32;
    localparam int DEPTH_DEF = 32;
    localparam int NRD_DEF   = 2;

endpackage

// File: rtl/regfile_sb.sv
// regfile_sb: per-register pending bits with set-over-clear
// priority and combinational busy lookup for each read port.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int NRD   = NRD_DEF,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            sb_set,
    input  logic [AW-1:0]   sb_addr,
    input  logic            we0,
    input  logic [AW-1:0]   wa0,
    input  logic            we1,
    input  logic [AW-1:0]   wa1,
    input  logic [NRD*AW-1:0] ra,
    output logic [NRD-1:0]  busy
);

    logic [DEPTH-1:0] pending;
    logic [DEPTH-1:0] pending_nxt;

    // Set is evaluated last so it overrides a same-cycle write clear.
    always_comb begin
        pending_nxt = pending;
        if (en) begin
            for (int i = 1; i < DEPTH; i++) begin
                if (we0 && wa0 == AW'(i))
                    pending_nxt[i] = 1'b0;
                if (we1 && wa1 == AW'(i))
                    pending_nxt[i] = 1'b0;
                if (sb_set && sb_addr == AW'(i))
                    pending_nxt[i] = 1'b1;
            end
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pending <= '0;
        else
            pending <= pending_nxt;
    end

    always_comb begin
        busy = '0;
        for (int k = 0; k < NRD; k++)
            busy[k] = en & pending[ra[k*AW +: AW]];
    end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read, dual-write register file with power-up
// clear sequence and scoreboard. Define RF_BYPASS_EN for write-to-read bypass.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int NRD   = NRD_DEF,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NRD*AW-1:0] ra,
    output logic [NRD*XLEN-1:0] rd,
    output logic [NRD-1:0]    busy,
    input  logic              we0,
    input  logic [AW-1:0]     wa0,
    input  logic [XLEN-1:0]   wd0,
    input  logic              we1,
    input  logic [AW-1:0]     wa1,
    input  logic [XLEN-1:0]   wd1,
    input  logic              sb_set,
    input  logic [AW-1:0]     sb_addr,
    output logic              ready
);

    state_t          state;
    logic [AW-1:0]   ptr;
    logic [XLEN-1:0] rf [DEPTH];
    logic            run;

    assign run = (state == RUN) && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CLEAR;
            ptr   <= AW'(1);
            ready <= 1'b0;
        end else begin
            unique case (state)
                CLEAR: begin
                    ptr <= ptr + AW'(1);
                    if (ptr == AW'(DEPTH - 1)) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                end
            endcase
        end
    end

    // No reset on storage; zeroing is done by the clear walk.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            rf[ptr] <= '0;
        end else begin
            if (we0 && wa0 != '0)
                rf[wa0] <= wd0;
            if (we1 && wa1 != '0)
                rf[wa1] <= wd1;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   a;
        logic [XLEN-1:0] d;

        assign a = ra[k*AW +: AW];

        always_comb begin
            d = rf[a];
`ifdef RF_BYPASS_EN
            if (we0 && wa0 == a)
                d = wd0;
            if (we1 && wa1 == a)
                d = wd1;
`endif
        end

        assign rd[k*XLEN +: XLEN] = (run && a != '0) ? d : '0;
    end

    regfile_sb #(
        .DEPTH (DEPTH),
        .NRD   (NRD)
    ) u_sb (
        .clk     (clk),
        .rst     (rst),
        .en      (run),
        .sb_set  (sb_set),
        .sb_addr (sb_addr),
        .we0     (we0),
        .wa0     (wa0),
        .we1     (we1),
        .wa1     (wa1),
        .ra      (ra),
        .busy    (busy)
    );

endmodule
